// File: rtl/instr_mem_loader.sv
// Instruction memory filled by a byte-stream loader FSM, read through a registered fetch port.
// Build with PARITY_EN defined to store an even-parity bit per word and flag mismatches on fetch.
module instr_mem_loader #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 8,
  parameter logic [DATA_W-1:0] RESET_INSTR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              parity_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   remaining;
  logic [BC_W-1:0]   bcnt;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W-1:0] wdata;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_word;
  logic              accept;
  logic              last_byte;
  logic              wr_en;
  logic              fetch_go;
  logic [ADDR_W:0]   len_clamped;

  assign load_ready  = (state == S_LOAD);
  assign load_done   = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign accept      = load_valid && load_ready;
  assign last_byte   = (bcnt == BC_W'(NB - 1));
  assign wr_en       = accept && last_byte && !reset;
  assign fetch_go    = fetch_en && (state == S_IDLE) && !reset;
  assign len_clamped = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign rd_word     = mem[fetch_addr];

  // Current byte merged into the partial word so the last byte can be written on its own edge.
  always_comb begin
    wdata = asm_word;
    for (int k = 0; k < NB; k++) begin
      if (bcnt == BC_W'(k)) wdata[8*k +: 8] = load_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wptr      <= '0;
      remaining <= '0;
      bcnt      <= '0;
      asm_word  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            wptr      <= load_base;
            remaining <= len_clamped;
            bcnt      <= '0;
            state     <= (len_clamped == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            asm_word <= wdata;
            if (last_byte) begin
              bcnt      <= '0;
              wptr      <= wptr + 1'b1;
              remaining <= remaining - 1'b1;
              if (remaining == (ADDR_W+1)'(1)) state <= S_DONE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset so a reset never destroys a loaded program.
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef PARITY_EN
      mem[wptr] <= {^wdata, wdata};
`else
      mem[wptr] <= wdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_out   <= RESET_INSTR;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_go;
      if (fetch_go) instr_out <= rd_word[DATA_W-1:0];
    end
  end

`ifdef PARITY_EN
  // Stored bit plus data XOR to 1 exactly when the even-parity relation is broken.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (fetch_go) begin
      parity_err <= ^rd_word;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader (DATA_W=16, ADDR_W=8): loads, wrap, stalls, blocked fetch, reset abort.
module tb_instr_mem_loader;
  logic        clk;
  logic        reset;
  logic        load_start;
  logic [7:0]  load_base;
  logic [8:0]  load_len;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        busy;
  logic        fetch_en;
  logic [7:0]  fetch_addr;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        parity_err;

  instr_mem_loader #(.DATA_W(16), .ADDR_W(8), .RESET_INSTR(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_byte(load_byte), .load_valid(load_valid), .load_ready(load_ready),
    .load_done(load_done), .busy(busy),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr_out(instr_out), .instr_valid(instr_valid), .parity_err(parity_err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [9];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];
  logic [15:0] wq [$];
  logic [15:0] held;
  logic        exp_par = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] base, input logic [8:0] len);
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit disturb);
    int t;
    t = 0;
    while (!load_ready && t < 20) begin
      step();
      t++;
    end
    chk("load_ready", load_ready, 1);
    load_byte  = b;
    load_valid = 1'b1;
    if (disturb) begin
      fetch_en   = 1'b1;
      fetch_addr = 8'h10;
      load_start = 1'b1;
      load_base  = 8'h80;
      load_len   = 9'd1;
    end
    step();
    load_valid = 1'b0;
    if (disturb) begin
      chk("blocked_valid", instr_valid, 0);
      chk("blocked_hold", instr_out, held);
    end
    for (int g = 0; g < gap; g++) begin
      step();
      chk("stall_busy", busy, 1);
      chk("stall_no_done", load_done, 0);
    end
  endtask

  // Loads the words queued in wq as a little-endian byte stream.
  task automatic load_words(input logic [7:0] base, input int gap, input bit disturb);
    int n;
    n = wq.size();
    start(base, 9'(n));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] w;
        w = wq[i];
        send_byte(w[8*k +: 8], (i == n - 1 && k == 1) ? 0 : gap, disturb);
      end
    end
    fetch_en   = 1'b0;
    load_start = 1'b0;
    chk("done_pulse", load_done, 1);
    chk("done_busy", busy, 1);
    step();
    chk("done_clear", load_done, 0);
    chk("back_idle", busy, 0);
    wq.delete();
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] e);
    fetch_en   = 1'b1;
    fetch_addr = a;
    exp_q.push_back(e);
    step();
    chk("fetch_valid", instr_valid, 1);
    if (exp_q.size() > 0) chk("fetch_data", instr_out, exp_q.pop_front());
    chk("fetch_parity", parity_err, exp_par);
  endtask

  task automatic fetch_end();
    logic [15:0] h;
    h = instr_out;
    fetch_en = 1'b0;
    step();
    chk("idle_valid", instr_valid, 0);
    chk("idle_hold", instr_out, h);
  endtask

  initial begin
    tbl[0] = '{8'h10, 16'h1234};
    tbl[1] = '{8'h11, 16'h5678};
    tbl[2] = '{8'hFF, 16'hAAAA};
    tbl[3] = '{8'h00, 16'hBBBB};
    tbl[4] = '{8'h30, 16'h1234};
    tbl[5] = '{8'h31, 16'h5678};
    tbl[6] = '{8'h20, 16'h2211};
    tbl[7] = '{8'h21, 16'hBEEF};
    tbl[8] = '{8'h50, 16'h7766};

    reset = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    load_byte = '0; load_valid = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
    step();
    step();
    chk("rst_instr_out", instr_out, 16'h0000);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_parity_err", parity_err, 0);
    reset = 1'b0;
    step();

    // Basic two-word load, then back-to-back fetch.
    wq = '{16'h1234, 16'h5678};
    load_words(8'h10, 0, 1'b0);
    fetch(8'h10, 16'h1234);
    fetch(8'h11, 16'h5678);
    fetch_end();

    // Wrap-around load with fetch requests and a second start attempted throughout.
    held = instr_out;
    wq = '{16'hAAAA, 16'hBBBB};
    load_words(8'hFF, 0, 1'b1);
    chk("ignored_start_idle", busy, 0);

    // Zero-length session leaves memory untouched.
    start(8'h10, 9'd0);
    chk("zero_len_done", load_done, 1);
    step();
    chk("zero_len_clear", load_done, 0);
    chk("zero_len_idle", busy, 0);
    fetch(8'h10, 16'h1234);
    fetch_end();

    // Stalled stream with 5-cycle gaps between bytes.
    wq = '{16'h1234, 16'h5678};
    load_words(8'h30, 5, 1'b0);

    // Reset in the middle of the second word of a load.
    wq = '{16'hCAFE, 16'hBEEF};
    load_words(8'h20, 0, 1'b0);
    start(8'h20, 9'd2);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_ready", load_ready, 0);
    chk("abort_instr_out", instr_out, 16'h0000);
    chk("abort_valid", instr_valid, 0);
    step();
    wq = '{16'h7766};
    load_words(8'h50, 0, 1'b0);

    // Read back everything from the table as one continuous fetch burst.
    for (int i = 0; i < 9; i++) fetch(tbl[i].addr, tbl[i].exp);
    fetch_end();

`ifdef PARITY_EN
    dut.mem[8'h10][0] = ~dut.mem[8'h10][0];
    exp_par = 1'b1;
    fetch(8'h10, 16'h1235);
    exp_par = 1'b0;
    fetch(8'h11, 16'h5678);
    fetch_end();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
